// File: rtl/muldiv_sequencer_if.sv
// Decode-side request/response bundle for the HI/LO multiply sequencer.
// The decoder drives requests through master; the sequencer answers through slave.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic             SIGNED;
  logic [WIDTH-1:0] OP_A;
  logic [WIDTH-1:0] OP_B;
  logic             READ_HI;
  logic             READ_LO;
  logic             STALL;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output START, SIGNED, OP_A, OP_B, READ_HI, READ_LO,
    input  STALL, BUSY, DONE, HI, LO
  );

  modport slave (
    input  START, SIGNED, OP_A, OP_B, READ_HI, READ_LO,
    output STALL, BUSY, DONE, HI, LO
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 shift-add MULT/MULTU sequencer: WIDTH iterations on magnitudes, then a
// sign-fix cycle that writes HI/LO. Stalls decode for hazards while busy.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  muldiv_sequencer_if.slave bus
);
  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [AW-1:0]    result;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value and process ordering cannot change behaviour.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.START) state_d = RUN;
      RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY  = (state_q != IDLE);
    bus.STALL = bus.BUSY & (bus.START | bus.READ_HI | bus.READ_LO);
    bus.DONE  = done_q;
    bus.HI    = hi_q;
    bus.LO    = lo_q;
  end

  // NOTE: every datapath next-state gets a hold default first, so no branch
  // of the case below can leave a variable unassigned and infer a latch.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == FIX);
    sum      = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    result   = neg_q ? (~acc_q + AW'(1)) : acc_q;
    unique case (state_q)
      IDLE: if (bus.START) begin
        mcand_d  = magnitude(bus.OP_A, bus.SIGNED);
        mplier_d = magnitude(bus.OP_B, bus.SIGNED);
        neg_d    = bus.SIGNED & (bus.OP_A[WIDTH-1] ^ bus.OP_B[WIDTH-1]);
        acc_d    = '0;
        cnt_d    = '0;
      end
      RUN: begin
        // Carry out of the upper-half add becomes the new accumulator MSB.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      FIX: begin
        hi_d = result[AW-1:WIDTH];
        lo_d = result[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // NOTE: the operand/accumulator registers are reset along with HI/LO so an
  // aborted operation leaves no residue; they are flops, not a memory array.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a 64-bit
// arithmetic product model.
module tb_muldiv_sequencer;
  logic CLK;
  logic RESET;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint p;
    logic [63:0] ua, ub;
    if (s) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Caller sits at a negedge; returns at the negedge of the DONE cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int lat, output logic busy0);
    bus.START  = 1'b1;
    bus.SIGNED = s;
    bus.OP_A   = a;
    bus.OP_B   = b;
    @(posedge CLK);
    @(negedge CLK);
    busy0      = bus.BUSY;
    bus.START  = 1'b0;
    bus.OP_A   = $urandom;
    bus.OP_B   = $urandom;
    bus.SIGNED = $urandom_range(0, 1);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (bus.DONE) break;
    end
    hi = bus.HI;
    lo = bus.LO;
  endtask

  task automatic test_reset();
    RESET       = 1'b1;
    bus.READ_HI = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total_cnt++; if (bus.HI !== 32'd0)  $display("FAIL reset_hi: got %h want 0", bus.HI);  else pass_cnt++;
    total_cnt++; if (bus.LO !== 32'd0)  $display("FAIL reset_lo: got %h want 0", bus.LO);  else pass_cnt++;
    total_cnt++; if (bus.DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.DONE); else pass_cnt++;
    total_cnt++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.BUSY); else pass_cnt++;
    total_cnt++; if (bus.STALL !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.STALL); else pass_cnt++;
    RESET       = 1'b0;
    bus.READ_HI = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    logic [31:0] va [5], vb [5], eh [5], el [5];
    logic        vs [5];
    logic [31:0] hi, lo;
    int          lat;
    logic        busy0;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; vs[0] = 0; eh[0] = 32'hFFFFFFFE; el[0] = 32'h00000001;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'd5;        vs[1] = 1; eh[1] = 32'hFFFFFFFF; el[1] = 32'hFFFFFFFB;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'd5;        vs[2] = 0; eh[2] = 32'h00000004; el[2] = 32'hFFFFFFFB;
    va[3] = 32'h80000000; vb[3] = 32'h80000000; vs[3] = 1; eh[3] = 32'h40000000; el[3] = 32'h00000000;
    va[4] = 32'h80000000; vb[4] = 32'd1;        vs[4] = 1; eh[4] = 32'hFFFFFFFF; el[4] = 32'h80000000;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vs[i], hi, lo, lat, busy0);
      total_cnt++; if (busy0 !== 1'b1) $display("FAIL dir%0d_busy: got %b want 1", i, busy0); else pass_cnt++;
      total_cnt++; if (lat !== 33)     $display("FAIL dir%0d_latency: got %0d want 33", i, lat); else pass_cnt++;
      total_cnt++; if (hi !== eh[i])   $display("FAIL dir%0d_hi: got %h want %h", i, hi, eh[i]); else pass_cnt++;
      total_cnt++; if (lo !== el[i])   $display("FAIL dir%0d_lo: got %h want %h", i, lo, el[i]); else pass_cnt++;
      repeat (3) @(negedge CLK);
      total_cnt++; if (bus.DONE !== 1'b0) $display("FAIL dir%0d_done_pulse: got %b want 0", i, bus.DONE); else pass_cnt++;
      total_cnt++; if ({bus.HI, bus.LO} !== {eh[i], el[i]})
        $display("FAIL dir%0d_hold: got %h want %h", i, {bus.HI, bus.LO}, {eh[i], el[i]}); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo;
    logic        s, busy0;
    logic [63:0] exp;
    int          lat;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      s = $urandom_range(0, 1);
      if (i % 5 == 0) a = 32'h80000000;
      if (i % 7 == 3) b = 32'd0;
      exp = ref_mul(a, b, s);
      do_op(a, b, s, hi, lo, lat, busy0);
      total_cnt++; if (lat !== 33) $display("FAIL rnd%0d_latency: got %0d want 33", i, lat); else pass_cnt++;
      total_cnt++; if ({hi, lo} !== exp)
        $display("FAIL rnd%0d_product: %h*%h s=%b got %h want %h", i, a, b, s, {hi, lo}, exp); else pass_cnt++;
    end
  endtask

  task automatic test_hazard();
    logic [63:0] exp;
    int          lat;
    exp = ref_mul(32'h00012345, 32'h00006789, 1'b0);
    bus.READ_LO = 1'b1;
    #1;
    total_cnt++; if (bus.STALL !== 1'b0) $display("FAIL idle_read_stall: got %b want 0", bus.STALL); else pass_cnt++;
    @(negedge CLK);
    bus.READ_LO = 1'b0;
    bus.START   = 1'b1;
    bus.SIGNED  = 1'b0;
    bus.OP_A    = 32'h00012345;
    bus.OP_B    = 32'h00006789;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (lat == 1) bus.READ_HI = 1'b1;
      if (lat == 5) begin
        bus.START = 1'b1;
        bus.OP_A  = 32'd9;
        bus.OP_B  = 32'd9;
      end
      if (lat == 8) bus.START = 1'b0;
      #1;
      if (bus.DONE) break;
      total_cnt++; if (bus.STALL !== 1'b1) $display("FAIL hazard_stall_c%0d: got %b want 1", lat, bus.STALL); else pass_cnt++;
    end
    total_cnt++; if (lat !== 33) $display("FAIL hazard_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (bus.STALL !== 1'b0) $display("FAIL hazard_unstall: got %b want 0", bus.STALL); else pass_cnt++;
    total_cnt++; if ({bus.HI, bus.LO} !== exp)
      $display("FAIL hazard_product: got %h want %h", {bus.HI, bus.LO}, exp); else pass_cnt++;
    bus.READ_HI = 1'b0;
    @(negedge CLK);
    total_cnt++; if (bus.BUSY !== 1'b0) $display("FAIL hazard_no_restart: got %b want 0", bus.BUSY); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] hi, lo;
    logic        busy0, seen_done;
    int          lat;
    bus.START  = 1'b1;
    bus.SIGNED = 1'b0;
    bus.OP_A   = 32'hDEADBEEF;
    bus.OP_B   = 32'h00001234;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET       = 1'b0;
    bus.READ_HI = 1'b1;
    #1;
    total_cnt++; if (bus.BUSY !== 1'b0)  $display("FAIL midrst_busy: got %b want 0", bus.BUSY);  else pass_cnt++;
    total_cnt++; if (bus.STALL !== 1'b0) $display("FAIL midrst_stall: got %b want 0", bus.STALL); else pass_cnt++;
    total_cnt++; if ({bus.HI, bus.LO} !== 64'd0) $display("FAIL midrst_hilo: got %h want 0", {bus.HI, bus.LO}); else pass_cnt++;
    bus.READ_HI = 1'b0;
    seen_done   = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.DONE) seen_done = 1'b1;
    end
    total_cnt++; if (seen_done !== 1'b0) $display("FAIL midrst_done: got %b want 0", seen_done); else pass_cnt++;
    do_op(32'd7, 32'd9, 1'b0, hi, lo, lat, busy0);
    total_cnt++; if (lat !== 33) $display("FAIL midrst_fresh_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'd63) $display("FAIL midrst_fresh_product: got %h want 63", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    logic        busy0;
    int          lat;
    do_op(32'h00000010, 32'h00000020, 1'b0, hi, lo, lat, busy0);
    total_cnt++; if ({hi, lo} !== 64'h200) $display("FAIL b2b_first: got %h want 200", {hi, lo}); else pass_cnt++;
    do_op(32'd3, 32'd4, 1'b0, hi, lo, lat, busy0);
    total_cnt++; if (busy0 !== 1'b1) $display("FAIL b2b_accept: got %b want 1", busy0); else pass_cnt++;
    total_cnt++; if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (lo !== 32'd12) $display("FAIL b2b_lo: got %h want c", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL b2b_hi: got %h want 0", hi); else pass_cnt++;
  endtask

  initial begin
    RESET       = 1'b1;
    bus.START   = 1'b0;
    bus.SIGNED  = 1'b0;
    bus.OP_A    = '0;
    bus.OP_B    = '0;
    bus.READ_HI = 1'b0;
    bus.READ_LO = 1'b0;
    @(negedge CLK);
    test_reset();
    test_directed();
    test_random();
    test_hazard();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
